// File: rtl/id_operand_stage_pkg.sv
// Shared constants and forward-select helper for the decode-stage operand path.
package id_operand_stage_pkg;

  localparam int unsigned ID_CTRL_W     = 16;
  localparam int unsigned ZERO_REG_ADDR = 0;
  localparam int unsigned HAZARD_CNT_W  = 16;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    FWD_GPR  = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_EX   = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

  // The zero register beats every forward source; EX is younger than MEM.
  function automatic fwd_sel_e fwd_select(input logic is_zero,
                                          input logic ex_hit,
                                          input logic mem_hit);
    fwd_sel_e sel;
    if (is_zero)      sel = FWD_ZERO;
    else if (ex_hit)  sel = FWD_EX;
    else if (mem_hit) sel = FWD_MEM;
    else              sel = FWD_GPR;
    return sel;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forward select: zero register, EX result, MEM result or GPR file.
module id_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic              rs_used_i,
  input  logic              ex_fwd_ok_i,
  input  logic [ADDR_W-1:0] ex_dst_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              mem_gpr_we_n_i,
  input  logic [ADDR_W-1:0] mem_dst_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] gpr_data_i,
  output logic [DATA_W-1:0] opnd_o
);

  logic     is_zero;
  logic     ex_hit;
  logic     mem_hit;
  fwd_sel_e sel;

  always_comb begin
    is_zero = (rs_addr_i == ADDR_W'(ZERO_REG_ADDR));
    ex_hit  = rs_used_i && ex_fwd_ok_i && (ex_dst_addr_i == rs_addr_i);
    mem_hit = (mem_gpr_we_n_i == ENABLE_) && (mem_dst_addr_i == rs_addr_i);
    sel     = fwd_select(is_zero, ex_hit, mem_hit);
    case (sel)
      FWD_EX:  opnd_o = ex_data_i;
      FWD_MEM: opnd_o = mem_data_i;
      FWD_GPR: opnd_o = gpr_data_i;
      default: opnd_o = '0;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand path: GPR read, EX/MEM forwarding, load-use hazard
// detection against in-flight loads, and the ID/EX pipeline register.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned CTRL_W   = ID_CTRL_W,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dec_en,
  input  logic [CTRL_W-1:0]        dec_ctrl,
  input  logic [NUM_RD*ADDR_W-1:0] dec_rs_addr,
  input  logic [NUM_RD-1:0]        dec_rs_used,
  input  logic [ADDR_W-1:0]        dec_dst_addr,
  input  logic                     dec_gpr_we_,
  input  logic                     dec_is_load,
  output logic [NUM_RD*ADDR_W-1:0] gpr_rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] gpr_rd_data,
  input  logic [DATA_W-1:0]        ex_fwd_data,
  input  logic [DATA_W-1:0]        mem_fwd_data,
  input  logic [ADDR_W-1:0]        mem_dst_addr,
  input  logic                     mem_gpr_we_,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     ld_hazard,
  output logic [HAZARD_CNT_W-1:0]  hazard_cnt,
  output logic                     id_en,
  output logic [CTRL_W-1:0]        id_ctrl,
  output logic [NUM_RD*DATA_W-1:0] id_opnd,
  output logic [ADDR_W-1:0]        id_dst_addr,
  output logic                     id_gpr_we_,
  output logic                     id_is_load
);

  logic                     id_en_q, id_en_d;
  logic [CTRL_W-1:0]        id_ctrl_q, id_ctrl_d;
  logic [NUM_RD*DATA_W-1:0] id_opnd_q, id_opnd_d;
  logic [ADDR_W-1:0]        id_dst_q, id_dst_d;
  logic                     id_gpr_we_n_q, id_gpr_we_n_d;
  logic                     id_is_load_q, id_is_load_d;
  logic [HAZARD_CNT_W-1:0]  hazard_cnt_q, hazard_cnt_d;

  logic [LOAD_LAT-1:0]             chain_vld_q, chain_vld_d;
  logic [LOAD_LAT-1:0][ADDR_W-1:0] chain_dst_q, chain_dst_d;

  logic                     ex_load;
  logic                     ex_alu_wr;
  logic [NUM_RD-1:0]        rs_hazard;
  logic [NUM_RD*DATA_W-1:0] fwd_opnd;

  // The instruction in EX is whatever this block last registered.
  assign ex_load   = id_en_q && (id_gpr_we_n_q == ENABLE_) && id_is_load_q;
  assign ex_alu_wr = id_en_q && (id_gpr_we_n_q == ENABLE_) && !id_is_load_q;

  assign gpr_rd_addr = dec_rs_addr;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_fwd
    id_fwd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_fwd (
      .rs_addr_i      (dec_rs_addr[k*ADDR_W +: ADDR_W]),
      .rs_used_i      (dec_rs_used[k]),
      .ex_fwd_ok_i    (ex_alu_wr),
      .ex_dst_addr_i  (id_dst_q),
      .ex_data_i      (ex_fwd_data),
      .mem_gpr_we_n_i (mem_gpr_we_),
      .mem_dst_addr_i (mem_dst_addr),
      .mem_data_i     (mem_fwd_data),
      .gpr_data_i     (gpr_rd_data[k*DATA_W +: DATA_W]),
      .opnd_o         (fwd_opnd[k*DATA_W +: DATA_W])
    );
  end

  // The last chain entry is skipped: its data is on the MEM forward path now.
  always_comb begin
    rs_hazard = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (dec_rs_used[k] &&
          dec_rs_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG_ADDR)) begin
        if (ex_load && id_dst_q == dec_rs_addr[k*ADDR_W +: ADDR_W])
          rs_hazard[k] = 1'b1;
        for (int unsigned i = 0; i + 1 < LOAD_LAT; i++) begin
          if (chain_vld_q[i] && chain_dst_q[i] == dec_rs_addr[k*ADDR_W +: ADDR_W])
            rs_hazard[k] = 1'b1;
        end
      end
    end
    ld_hazard = dec_en && (|rs_hazard);
  end

  always_comb begin
    chain_vld_d = chain_vld_q;
    chain_dst_d = chain_dst_q;
    if (!stall) begin
      chain_vld_d[0] = ex_load;
      chain_dst_d[0] = id_dst_q;
      for (int unsigned i = 1; i < LOAD_LAT; i++) begin
        chain_vld_d[i] = chain_vld_q[i-1];
        chain_dst_d[i] = chain_dst_q[i-1];
      end
    end
  end

  always_comb begin
    id_en_d       = id_en_q;
    id_ctrl_d     = id_ctrl_q;
    id_opnd_d     = id_opnd_q;
    id_dst_d      = id_dst_q;
    id_gpr_we_n_d = id_gpr_we_n_q;
    id_is_load_d  = id_is_load_q;
    hazard_cnt_d  = hazard_cnt_q;
    if (!stall) begin
      if (flush || ld_hazard) begin
        id_en_d       = 1'b0;
        id_ctrl_d     = '0;
        id_opnd_d     = '0;
        id_dst_d      = '0;
        id_gpr_we_n_d = DISABLE_;
        id_is_load_d  = 1'b0;
      end else begin
        id_en_d       = dec_en;
        id_ctrl_d     = dec_ctrl;
        id_opnd_d     = fwd_opnd;
        id_dst_d      = dec_dst_addr;
        id_gpr_we_n_d = dec_en ? dec_gpr_we_ : DISABLE_;
        id_is_load_d  = dec_en && dec_is_load;
      end
      if (ld_hazard && !flush && hazard_cnt_q != '1)
        hazard_cnt_d = hazard_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_en_q       <= 1'b0;
      id_ctrl_q     <= '0;
      id_opnd_q     <= '0;
      id_dst_q      <= '0;
      id_gpr_we_n_q <= DISABLE_;
      id_is_load_q  <= 1'b0;
      hazard_cnt_q  <= '0;
      chain_vld_q   <= '0;
      chain_dst_q   <= '0;
    end else begin
      id_en_q       <= id_en_d;
      id_ctrl_q     <= id_ctrl_d;
      id_opnd_q     <= id_opnd_d;
      id_dst_q      <= id_dst_d;
      id_gpr_we_n_q <= id_gpr_we_n_d;
      id_is_load_q  <= id_is_load_d;
      hazard_cnt_q  <= hazard_cnt_d;
      chain_vld_q   <= chain_vld_d;
      chain_dst_q   <= chain_dst_d;
    end
  end

  assign id_en       = id_en_q;
  assign id_ctrl     = id_ctrl_q;
  assign id_opnd     = id_opnd_q;
  assign id_dst_addr = id_dst_q;
  assign id_gpr_we_  = id_gpr_we_n_q;
  assign id_is_load  = id_is_load_q;
  assign hazard_cnt  = hazard_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: three instances (LOAD_LAT 1, 3, 4) share stimulus
// and are compared against an in-flight-load scoreboard model.
module tb_id_operand_stage;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_en;
  logic [15:0] dec_ctrl;
  logic [9:0]  dec_rs_addr;
  logic [1:0]  dec_rs_used;
  logic [4:0]  dec_dst_addr;
  logic        dec_gpr_we_;
  logic        dec_is_load;
  logic [63:0] gpr_rd_data;
  logic [31:0] ex_fwd_data;
  logic [31:0] mem_fwd_data;
  logic [4:0]  mem_dst_addr;
  logic        mem_gpr_we_;
  logic        stall;
  logic        flush;

  logic [9:0]  gpr_rd_addr_w [NI];
  logic        ld_hazard_w   [NI];
  logic [15:0] hazard_cnt_w  [NI];
  logic        id_en_w       [NI];
  logic [15:0] id_ctrl_w     [NI];
  logic [63:0] id_opnd_w     [NI];
  logic [4:0]  id_dst_w      [NI];
  logic        id_we_w       [NI];
  logic        id_ld_w       [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    id_operand_stage #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_RD   (2),
      .CTRL_W   (16),
      .LOAD_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .dec_en       (dec_en),
      .dec_ctrl     (dec_ctrl),
      .dec_rs_addr  (dec_rs_addr),
      .dec_rs_used  (dec_rs_used),
      .dec_dst_addr (dec_dst_addr),
      .dec_gpr_we_  (dec_gpr_we_),
      .dec_is_load  (dec_is_load),
      .gpr_rd_addr  (gpr_rd_addr_w[g]),
      .gpr_rd_data  (gpr_rd_data),
      .ex_fwd_data  (ex_fwd_data),
      .mem_fwd_data (mem_fwd_data),
      .mem_dst_addr (mem_dst_addr),
      .mem_gpr_we_  (mem_gpr_we_),
      .stall        (stall),
      .flush        (flush),
      .ld_hazard    (ld_hazard_w[g]),
      .hazard_cnt   (hazard_cnt_w[g]),
      .id_en        (id_en_w[g]),
      .id_ctrl      (id_ctrl_w[g]),
      .id_opnd      (id_opnd_w[g]),
      .id_dst_addr  (id_dst_w[g]),
      .id_gpr_we_   (id_we_w[g]),
      .id_is_load   (id_ld_w[g])
    );
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned sat_raw = 0;

  // Reference model: architectural ID/EX contents plus a list of loads that
  // have left EX, each tagged with how many pipeline advances ago.
  logic        m_en   [NI];
  logic [15:0] m_ctrl [NI];
  logic [63:0] m_opnd [NI];
  logic [4:0]  m_dst  [NI];
  logic        m_we   [NI];
  logic        m_ld   [NI];
  int unsigned m_cnt  [NI];
  bit          fl_busy[NI][8];
  int unsigned fl_age [NI][8];
  logic [4:0]  fl_dst [NI][8];

  function automatic int unsigned lat(input int n);
    return (n == 0) ? 1 : (n == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int n);
    m_en[n] = 0; m_ctrl[n] = '0; m_opnd[n] = '0; m_dst[n] = '0;
    m_we[n] = 1; m_ld[n] = 0; m_cnt[n] = 0;
    for (int s = 0; s < 8; s++) fl_busy[n][s] = 0;
  endtask

  function automatic logic [31:0] exp_opnd(input int n, input int k);
    logic [4:0] a;
    a = dec_rs_addr[k*5 +: 5];
    if (a == 5'd0) return 32'd0;
    if (dec_rs_used[k] && m_en[n] && !m_we[n] && !m_ld[n] && m_dst[n] == a) return ex_fwd_data;
    if (!mem_gpr_we_ && mem_dst_addr == a) return mem_fwd_data;
    return gpr_rd_data[k*32 +: 32];
  endfunction

  function automatic bit exp_hazard(input int n);
    logic [4:0] a;
    bit h;
    h = 0;
    if (!dec_en) return 0;
    for (int k = 0; k < 2; k++) begin
      a = dec_rs_addr[k*5 +: 5];
      if (dec_rs_used[k] && a != 5'd0) begin
        if (m_en[n] && m_ld[n] && !m_we[n] && m_dst[n] == a) h = 1;
        for (int s = 0; s < 8; s++)
          if (fl_busy[n][s] && fl_age[n][s] < lat(n) && fl_dst[n][s] == a) h = 1;
      end
    end
    return h;
  endfunction

  task automatic model_advance(input int n, input bit hz, input logic [63:0] op);
    if (!reset) begin
      model_reset(n);
      return;
    end
    if (stall) return;
    for (int s = 0; s < 8; s++) begin
      if (fl_busy[n][s]) begin
        fl_age[n][s]++;
        if (fl_age[n][s] >= lat(n)) fl_busy[n][s] = 0;
      end
    end
    if (m_en[n] && m_ld[n] && !m_we[n] && lat(n) > 1) begin
      for (int s = 0; s < 8; s++) begin
        if (!fl_busy[n][s]) begin
          fl_busy[n][s] = 1; fl_age[n][s] = 1; fl_dst[n][s] = m_dst[n];
          break;
        end
      end
    end
    if (hz && !flush) begin
      if (m_cnt[n] < 65535) m_cnt[n]++;
      if (n == 2) sat_raw++;
    end
    if (flush || hz) begin
      m_en[n] = 0; m_ctrl[n] = '0; m_opnd[n] = '0; m_dst[n] = '0; m_we[n] = 1; m_ld[n] = 0;
    end else begin
      m_en[n] = dec_en; m_ctrl[n] = dec_ctrl; m_opnd[n] = op; m_dst[n] = dec_dst_addr;
      m_we[n] = dec_en ? dec_gpr_we_ : 1'b1;
      m_ld[n] = dec_en && dec_is_load;
    end
  endtask

  task automatic step(input bit chk_on);
    bit          hz [NI];
    logic [63:0] op [NI];
    @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      hz[n] = exp_hazard(n);
      op[n] = {exp_opnd(n, 1), exp_opnd(n, 0)};
    end
    if (chk_on) begin
      chk("gpr_rd_addr", 64'(gpr_rd_addr_w[0]), 64'(dec_rs_addr));
      for (int n = 0; n < NI; n++) chk($sformatf("ld_hazard[%0d]", n), 64'(ld_hazard_w[n]), 64'(hz[n]));
    end
    for (int n = 0; n < NI; n++) model_advance(n, hz[n], op[n]);
    @(posedge clk);
    #1;
    if (chk_on) begin
      for (int n = 0; n < NI; n++) begin
        chk($sformatf("id_en[%0d]", n),      64'(id_en_w[n]),      64'(m_en[n]));
        chk($sformatf("id_ctrl[%0d]", n),    64'(id_ctrl_w[n]),    64'(m_ctrl[n]));
        chk($sformatf("id_opnd[%0d]", n),    id_opnd_w[n],         m_opnd[n]);
        chk($sformatf("id_dst[%0d]", n),     64'(id_dst_w[n]),     64'(m_dst[n]));
        chk($sformatf("id_we_[%0d]", n),     64'(id_we_w[n]),      64'(m_we[n]));
        chk($sformatf("id_ld[%0d]", n),      64'(id_ld_w[n]),      64'(m_ld[n]));
        chk($sformatf("hazard_cnt[%0d]", n), 64'(hazard_cnt_w[n]), 64'(m_cnt[n]));
      end
    end
  endtask

  task automatic nop();
    dec_en = 0; dec_ctrl = '0; dec_rs_addr = '0; dec_rs_used = '0; dec_dst_addr = '0;
    dec_gpr_we_ = 1; dec_is_load = 0; mem_gpr_we_ = 1; mem_dst_addr = '0;
    stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [15:0] ctrl, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] dst, input logic we_n,
                       input logic ld);
    dec_en = 1; dec_ctrl = ctrl; dec_rs_addr = {rs1, rs0}; dec_rs_used = used;
    dec_dst_addr = dst; dec_gpr_we_ = we_n; dec_is_load = ld;
  endtask

  task automatic sync_reset();
    nop();
    reset = 0;
    step(1);
    reset = 1;
  endtask

  initial begin
    int guard;
    reset = 0;
    nop();
    gpr_rd_data = 64'h0000_BEEF_0000_DEAD;
    ex_fwd_data = 32'h1111_0000;
    mem_fwd_data = 32'h2222_0000;
    for (int n = 0; n < NI; n++) model_reset(n);

    // Reset held with a valid instruction presented.
    issue(16'h00A5, 5'd1, 5'd2, 2'b11, 5'd9, 1'b0, 1'b0);
    repeat (3) step(1);
    for (int n = 0; n < NI; n++) begin
      chk("rst_id_en", 64'(id_en_w[n]), 64'd0);
      chk("rst_id_we_", 64'(id_we_w[n]), 64'd1);
      chk("rst_cnt", 64'(hazard_cnt_w[n]), 64'd0);
    end
    reset = 1;
    step(1);
    chk("post_rst_en", 64'(id_en_w[0]), 64'd1);
    chk("post_rst_dst", 64'(id_dst_w[0]), 64'd9);

    // EX forward beats MEM forward and GPR.
    sync_reset();
    issue(16'h0001, 5'd1, 5'd2, 2'b11, 5'd3, 1'b0, 1'b0);
    step(1);
    issue(16'h0002, 5'd3, 5'd0, 2'b01, 5'd4, 1'b0, 1'b0);
    ex_fwd_data = 32'h11; mem_fwd_data = 32'h22; mem_dst_addr = 5'd3; mem_gpr_we_ = 0;
    step(1);
    for (int n = 0; n < NI; n++) chk("exfwd_opnd0", 64'(id_opnd_w[n][31:0]), 64'h11);

    // Load-use across all latencies.
    sync_reset();
    issue(16'h0010, 5'd1, 5'd0, 2'b01, 5'd5, 1'b0, 1'b1);
    step(1);
    issue(16'h0020, 5'd5, 5'd0, 2'b01, 5'd6, 1'b0, 1'b0);
    step(1);
    chk("lu_bubble", 64'(id_en_w[0]), 64'd0);
    chk("lu_cnt1", 64'(hazard_cnt_w[0]), 64'd1);
    mem_dst_addr = 5'd5; mem_gpr_we_ = 0; mem_fwd_data = 32'h55; gpr_rd_data = 64'hAAAA;
    step(1);
    chk("lu_mem_en", 64'(id_en_w[0]), 64'd1);
    chk("lu_mem_opnd", 64'(id_opnd_w[0][31:0]), 64'h55);
    repeat (3) step(1);
    chk("lu_cnt_lat1", 64'(hazard_cnt_w[0]), 64'd1);
    chk("lu_cnt_lat3", 64'(hazard_cnt_w[1]), 64'd3);
    chk("lu_cnt_lat4", 64'(hazard_cnt_w[2]), 64'd4);
    chk("lu_lat4_en", 64'(id_en_w[2]), 64'd1);
    chk("lu_lat3_opnd", 64'(id_opnd_w[1][31:0]), 64'h55);

    // A load to r0 never creates a hazard.
    sync_reset();
    issue(16'h0030, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b1);
    step(1);
    issue(16'h0031, 5'd0, 5'd0, 2'b11, 5'd2, 1'b0, 1'b0);
    step(1);
    for (int n = 0; n < NI; n++) begin
      chk("r0_cnt", 64'(hazard_cnt_w[n]), 64'd0);
      chk("r0_en", 64'(id_en_w[n]), 64'd1);
      chk("r0_opnd", id_opnd_w[n], 64'd0);
    end

    // Stall beats flush; flush alone bubbles but keeps the older load live.
    sync_reset();
    issue(16'h0040, 5'd1, 5'd0, 2'b01, 5'd7, 1'b0, 1'b1);
    step(1);
    issue(16'h0041, 5'd7, 5'd0, 2'b01, 5'd8, 1'b0, 1'b0);
    stall = 1; flush = 1;
    step(1);
    for (int n = 0; n < NI; n++) begin
      chk("sf_hold_dst", 64'(id_dst_w[n]), 64'd7);
      chk("sf_hold_ld", 64'(id_ld_w[n]), 64'd1);
      chk("sf_hold_cnt", 64'(hazard_cnt_w[n]), 64'd0);
    end
    stall = 0;
    step(1);
    for (int n = 0; n < NI; n++) chk("flush_bubble", 64'(id_en_w[n]), 64'd0);
    flush = 0;
    step(1);
    chk("flush_lat1_en", 64'(id_en_w[0]), 64'd1);
    chk("flush_lat3_cnt", 64'(hazard_cnt_w[1]), 64'd1);
    chk("flush_lat3_en", 64'(id_en_w[1]), 64'd0);

    // Asynchronous reset in the middle of a stalled hazard.
    stall = 1;
    @(negedge clk);
    reset = 0;
    #1;
    for (int n = 0; n < NI; n++) begin
      chk("arst_en", 64'(id_en_w[n]), 64'd0);
      chk("arst_cnt", 64'(hazard_cnt_w[n]), 64'd0);
      chk("arst_hz", 64'(ld_hazard_w[n]), 64'd0);
      chk("arst_we_", 64'(id_we_w[n]), 64'd1);
      model_reset(n);
    end
    @(posedge clk);
    #1;
    reset = 1; stall = 0;
    step(1);
    for (int n = 0; n < NI; n++) begin
      chk("arst_resume_en", 64'(id_en_w[n]), 64'd1);
      chk("arst_resume_cnt", 64'(hazard_cnt_w[n]), 64'd0);
    end

    // Randomized traffic with a small register window for frequent hits.
    sync_reset();
    for (int i = 0; i < 400; i++) begin
      dec_en       = ($urandom_range(0, 9) != 0);
      dec_ctrl     = 16'($urandom);
      dec_rs_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      dec_rs_used  = 2'($urandom_range(0, 3));
      dec_dst_addr = 5'($urandom_range(0, 3));
      dec_gpr_we_  = ($urandom_range(0, 3) == 0);
      dec_is_load  = ($urandom_range(0, 2) == 0);
      gpr_rd_data  = {$urandom, $urandom};
      ex_fwd_data  = $urandom;
      mem_fwd_data = $urandom;
      mem_dst_addr = 5'($urandom_range(0, 3));
      mem_gpr_we_  = 1'($urandom_range(0, 1));
      stall        = ($urandom_range(0, 6) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      step(1);
    end

    // Saturation: a self-dependent load stream hazards 4 of every 5 cycles at LOAD_LAT=4.
    sync_reset();
    sat_raw = 0;
    issue(16'h0050, 5'd5, 5'd0, 2'b01, 5'd5, 1'b0, 1'b1);
    guard = 0;
    while (sat_raw < 65540 && guard < 90000) begin
      step(0);
      guard++;
    end
    chk("sat_within_budget", 64'(sat_raw >= 65540), 64'd1);
    for (int n = 0; n < NI; n++) chk($sformatf("sat_cnt_model[%0d]", n), 64'(hazard_cnt_w[n]), 64'(m_cnt[n]));
    chk("sat_cnt_ffff", 64'(hazard_cnt_w[2]), 64'hFFFF);
    repeat (5) step(1);
    chk("sat_cnt_stable", 64'(hazard_cnt_w[2]), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
